// File: rtl/io_host_pkg.sv
// Shared definitions for the I/O chip host sequencer: state encoding and
// fixed constants for the mode write and the returned-nibble format check.
package io_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRMODE,
      UPD_HI,
      UPD_LO,
      RD,
      TAIL,
      FIN
   } io_state_e;

   // Default chip address that receives the mode nibble.
   localparam logic [5:0] MODE_ADRS_DEF = 6'h08;

   // Upper nibble every well-formed chip read must carry.
   localparam logic [3:0] NIBBLE_PAD = 4'hF;

endpackage

// File: rtl/io_host_seq.sv
// Bus-master sequencer for the I/O chip's nibble RAM. Each accepted START
// writes the mode nibble, pulses UPDATE, then reads NREAD nibbles from
// address 0 upward into SNAP. The FSM state always runs one cycle ahead of
// the registered chip outputs, so every output is a flop and START can be
// re-accepted the cycle after DONE.
module io_host_seq
   import io_host_pkg::*;
#(
   parameter logic [5:0] MODE_ADRS = MODE_ADRS_DEF,
   parameter int         UPD_LEN   = 2,
   parameter int         NREAD     = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 START,
   input  logic [3:0]           MODE,
   output logic                 IO_EN,
   output logic                 IO_WR,
   output logic [5:0]           IO_ADRS,
   output logic [7:0]           IO_DOUT,
   output logic                 IO_UPDATE,
   input  logic [7:0]           IO_DIN,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [4*NREAD-1:0]   SNAP,
   output logic                 FMT_ERR
);

   localparam int         UPD_W   = $clog2(UPD_LEN + 1);
   localparam int         IDX_W   = (NREAD > 1) ? $clog2(NREAD) : 1;
   localparam logic [3:0] RD_LAST = 4'(NREAD - 1);

   io_state_e               state_q, state_d;
   logic [UPD_W-1:0]        upd_cnt_q, upd_cnt_d;
   logic [3:0]              rd_idx_q, rd_idx_d;
   logic                    accept;

   logic                    io_en_q, io_en_d;
   logic                    io_wr_q, io_wr_d;
   logic [5:0]              io_adrs_q, io_adrs_d;
   logic                    io_upd_q, io_upd_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic [3:0]              mode_q;
   logic [NREAD-1:0][3:0]   snap_q;
   logic                    fmt_err_q;
   logic                    cap_v_q;
   logic [IDX_W-1:0]        cap_idx_q;

   // Next state, counters and the chip-side outputs for the coming cycle.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
      state_d   = state_q;
      upd_cnt_d = upd_cnt_q;
      rd_idx_d  = rd_idx_q;
      accept    = 1'b0;
      io_en_d   = 1'b0;
      io_wr_d   = 1'b0;
      io_adrs_d = 6'h00;
      io_upd_d  = 1'b0;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (START) begin
               accept    = 1'b1;
               upd_cnt_d = '0;
               rd_idx_d  = '0;
               state_d   = WRMODE;
            end
         end
         WRMODE: begin
            io_en_d   = 1'b1;
            io_wr_d   = 1'b1;
            io_adrs_d = MODE_ADRS;
            upd_cnt_d = UPD_W'(UPD_LEN);
            state_d   = UPD_HI;
         end
         UPD_HI: begin
            io_upd_d  = 1'b1;
            upd_cnt_d = upd_cnt_q - UPD_W'(1);
            if (upd_cnt_q == UPD_W'(1)) state_d = UPD_LO;
         end
         UPD_LO: begin
            // One cycle of UPDATE low so the chip's edge detector re-arms.
            state_d = RD;
         end
         RD: begin
            io_en_d   = 1'b1;
            io_adrs_d = {2'b00, rd_idx_q};
            rd_idx_d  = rd_idx_q + 4'd1;
            if (rd_idx_q == RD_LAST) state_d = TAIL;
         end
         TAIL: begin
            state_d = FIN;
         end
         FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         upd_cnt_q <= '0;
         rd_idx_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
         state_q   <= state_d;
         upd_cnt_q <= upd_cnt_d;
         rd_idx_q  <= rd_idx_d;
      end
   end

   // Output registers; reset drops any write or UPDATE pulse in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         io_en_q   <= 1'b0;
         io_wr_q   <= 1'b0;
         io_adrs_q <= 6'h00;
         io_upd_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         io_en_q   <= io_en_d;
         io_wr_q   <= io_wr_d;
         io_adrs_q <= io_adrs_d;
         io_upd_q  <= io_upd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Mode latch, read-data capture into the addressed SNAP nibble, format check.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mode_q    <= 4'h0;
         // NOTE: SNAP is a small flop bank, not a RAM, so it is reset along with everything else.
         snap_q    <= '0;
         fmt_err_q <= 1'b0;
         cap_v_q   <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         // The chip registers read data one cycle after the read strobe.
         cap_v_q   <= io_en_q & ~io_wr_q;
         cap_idx_q <= io_adrs_q[IDX_W-1:0];
         if (accept) begin
            mode_q    <= MODE;
            fmt_err_q <= 1'b0;
         end
         if (cap_v_q) begin
            snap_q[cap_idx_q] <= IO_DIN[3:0];
            if (IO_DIN[7:4] != NIBBLE_PAD) fmt_err_q <= 1'b1;
         end
      end
   end

   assign IO_EN     = io_en_q;
   assign IO_WR     = io_wr_q;
   assign IO_ADRS   = io_adrs_q;
   assign IO_DOUT   = {4'h0, mode_q};
   assign IO_UPDATE = io_upd_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign SNAP      = snap_q;
   assign FMT_ERR   = fmt_err_q;

endmodule

// File: doc/io_host_seq.md
# io_host_seq

Bus-master sequencer for the custom I/O chip's shared nibble RAM. It drives the chip's ENABLE/WR/ADRS/IN/UPDATE side and captures OUT. On each START it performs one fixed transaction:
- write the mode nibble,
- pulse UPDATE,
- read back NREAD result nibbles into a snapshot register.

It sits between the frame-tick logic and the I/O chip, and is used by bench harnesses and by the sound/sub-CPU stub for machines whose host CPU is not modelled. An external mux arbitrates chip ownership against the real CPU.

## Interface
Parameters:
- MODE_ADRS, 6'h08: address written with MODE at the start of a transaction.
- UPD_LEN, 2: number of cycles IO_UPDATE is held high (≥1).
- NREAD, 8: number of nibbles read from address 0 upward (1..16).

Ports:
- CLK  in  1  single system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  transaction request, sampled only in IDLE.
- MODE  in  4  mode nibble; captured at START acceptance.
- IO_EN  out  1  chip ENABLE.
- IO_WR  out  1  chip WR; only ever high together with IO_EN.
- IO_ADRS  out  6  chip ADRS.
- IO_DOUT  out  8  chip IN; {4'h0, mode_q}.
- IO_UPDATE  out  1  chip UPDATE.
- IO_DIN  in  8  chip OUT; registered data, valid one cycle after the IO_EN read cycle.
- BUSY  out  1  high from the cycle after START acceptance through the tail cycle.
- DONE  out  1  one-cycle pulse; SNAP is complete in that cycle.
- SNAP  out  4*NREAD  nibble k (read from address k) at bits [4k+3:4k].
- FMT_ERR  out  1  sticky; set if any captured IO_DIN[7:4] ≠ 4'hF; cleared at START acceptance.

## Operation
- States: IDLE → WRMODE → UPD_HI → UPD_LO → RD → TAIL → FIN → IDLE.
- IDLE
  - All IO_* outputs are 0 except IO_DOUT, which holds {4'h0, mode_q}.
  - START=1 latches MODE into mode_q, clears FMT_ERR and the counters, then goes to WRMODE.
  - START while not IDLE is ignored and is not queued.
- WRMODE (1 cycle): IO_EN=1, IO_WR=1, IO_ADRS=MODE_ADRS.
- UPD_HI (UPD_LEN cycles): IO_UPDATE=1, IO_EN=0. A down-counter of width clog2(UPD_LEN+1) tracks the cycles.
- UPD_LO (1 cycle): IO_UPDATE=0. This guarantees the chip's edge detector re-arms before the next transaction.
- RD (NREAD cycles)
  - IO_EN=1, IO_WR=0, IO_ADRS={2'b00, rd_idx}; rd_idx runs 0..NREAD-1.
  - In each RD cycle after the first, IO_DIN[3:0] is captured into the nibble of SNAP for rd_idx-1.
- TAIL (1 cycle): IO_EN=0; the last nibble (index NREAD-1) is captured.
- FIN (1 cycle): DONE=1, BUSY=0, then return to IDLE.
- SNAP update rule: each nibble updates only in its own capture cycle. All other nibbles hold their values from the previous transaction until they are overwritten.
- FMT_ERR check: evaluated on every capture (NREAD captures per transaction).
- RESET (asynchronous, at any time, including mid-transaction)
  - state=IDLE; all IO_* outputs, BUSY, DONE and FMT_ERR go to 0.
  - SNAP=0, mode_q=0, counters=0.
  - No partial write or UPDATE edge continues after reset is asserted.

## Timing
- Cycle 0 is the posedge at which START=1 is sampled in IDLE. Cycle numbers below are posedge-relative registered outputs.
- Cycle 1: WRMODE write.
- Cycles 2 .. UPD_LEN+1: IO_UPDATE high.
- Cycle UPD_LEN+2: UPD_LO.
- Cycles UPD_LEN+3 .. UPD_LEN+2+NREAD: reads of addresses 0..NREAD-1.
- Cycle UPD_LEN+3+NREAD: TAIL.
- Cycle UPD_LEN+4+NREAD: DONE=1.
- With defaults, DONE is at cycle 14.
- BUSY is high for cycles 1 .. UPD_LEN+3+NREAD.
- Back-to-back: START held high continuously is re-accepted in the FIN→IDLE cycle+1. The minimum period is UPD_LEN+5+NREAD cycles.
- All outputs are registered; there is no combinational path from IO_DIN to any output.

## Structure
- Shared package io_host_pkg:
  - state enum (IDLE, WRMODE, UPD_HI, UPD_LO, RD, TAIL, FIN);
  - MODE_ADRS_DEF=6'h08;
  - NIBBLE_PAD=4'hF constant used by the FMT_ERR check.
- Single module, no sub-module. SNAP capture is an indexed nibble write, not a shifter, so that partial-update semantics hold.

## Test plan
- Default parameters, MODE=4'h8, chip model with nibbles 0..7 preloaded as 1..8: write at cycle 1 to address 0x08 with data 8'h08; IO_UPDATE high in cycles 2–3; DONE at cycle 14; SNAP=32'h87654321; FMT_ERR=0.
- START pulses during BUSY (cycles 3 and 9): ignored, exactly one DONE, no extra IO_WR.
- Model returns 8'h0A on address 5: SNAP nibble 5 = 4'hA; FMT_ERR=1 from the capture cycle until the next START acceptance, where it clears.
- RESET asserted asynchronously at cycle 6 (mid-RD), between clock edges: IO_EN, IO_UPDATE, BUSY, SNAP and FMT_ERR are 0 immediately; after release, a new START completes normally in 14 cycles.
- START held high for 40 cycles: DONE at cycles 14, 29 and so on, 15-cycle period; IO_UPDATE returns low for at least 1 cycle between its high pulses.
- UPD_LEN=1, NREAD=1: DONE at cycle 6; only SNAP[3:0] is written.
